mmio_port_decoder: RTL and testbench
====================================

Name: mmio_port_decoder

Overview:
Parametrised memory-mapped I/O decoder and access sequencer for the multicycle MIPS core. It generalises fixed single-address compares (GPIO 0x10010024, UART 0x10010020) to NUM_CH word-aligned channels at BASE_ADDR + 4*i. Each access gets a registered one-hot select, a strobe, an ack handshake with timeout, and a read-data mux. It sits between the core's memory stage and the peripherals (GPIO, UART, timers); addresses outside the window go to data memory.

Parameters:
WORD_LENGTH, 32, address/data width
NUM_CH, 4, number of peripheral channels (1..16)
BASE_ADDR, 32'h10010020, address of channel 0; channel i at BASE_ADDR + 4*i
TIMEOUT, 15, max cycles waiting for ack before bus error (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  core requests access (held until req_done)
req_write  input  1  1 = write, 0 = read
AddressIn  input  WORD_LENGTH  byte address from ALU result
WriteData  input  WORD_LENGTH  store data
is_mmio  output  1  combinational: AddressIn within [BASE_ADDR, BASE_ADDR+4*NUM_CH), word aligned
ch_sel  output  NUM_CH  registered one-hot channel select
ch_wr  output  1  write strobe to selected channel
ch_rd  output  1  read strobe to selected channel
ch_wdata  output  WORD_LENGTH  registered write data
ch_ack  input  NUM_CH  per-channel completion, rdata valid same cycle
ch_rdata  input  NUM_CH*WORD_LENGTH  packed read data, channel i at [i*W +: W]
req_done  output  1  one-cycle pulse: access complete
ReadData  output  WORD_LENGTH  read result, valid on req_done, held until next access
bus_error  output  1  sticky: timeout or misaligned MMIO access; cleared only by reset

Behaviour:
- Reset: state IDLE; ch_sel=0, ch_wr=0, ch_rd=0, ch_wdata=0, req_done=0, ReadData=0, bus_error=0, timeout counter=0.
- Index = (AddressIn - BASE_ADDR) >> 2. Misaligned means AddressIn[1:0] != 0 while the upper bits fall inside the window.
- is_mmio is purely combinational. Every other output is registered.
- IDLE: on req_valid & is_mmio -> ACCESS, latching ch_sel=onehot(index), ch_wdata, and ch_wr=req_write or ch_rd=~req_write.
- IDLE: on req_valid with a misaligned in-window address -> set bus_error, pulse req_done next cycle with ReadData=0; no strobe issued.
- IDLE: req_valid & ~is_mmio is ignored (data memory handles it).
- ACCESS: strobes (ch_wr/ch_rd) stay high until ack or timeout; ch_sel stays stable throughout. Each cycle the counter increments.
  - If ch_ack[sel] = 1 -> DONE; on a read, capture ch_rdata[sel] into ReadData.
  - Else if counter == TIMEOUT -> DONE; set bus_error, ReadData = 32'hDEADBEEF on reads.
  - Ack and timeout in the same cycle: ack wins, no error.
- ch_ack bits of unselected channels are ignored.
- DONE: req_done=1 for exactly one cycle; ch_sel, ch_wr, ch_rd and the counter clear; -> IDLE.
- Minimum latency: request seen in cycle 0, strobe in cycle 1, ack in cycle 1, req_done in cycle 2.
- A new request is accepted no earlier than the cycle after req_done.
- Reset mid-access: all state and outputs return to reset values on the next edge; no req_done is issued.
- A change of AddressIn during ACCESS has no effect, because the select is latched.

Decomposition:
- Shared package mmio_pkg:
  - state encoding (IDLE, ACCESS, DONE)
  - BUS_ERR_DATA = 32'hDEADBEEF
  - default BASE_ADDR
  - channel index constants CH_UART=0, CH_GPIO=1
- Sub-module mmio_addr_match (combinational): computes in_window, aligned, and one-hot index from AddressIn, BASE_ADDR and NUM_CH.
- The FSM, timeout counter and read mux stay in the top module.

Test Plan:
- Reset, then write 0x000000A5 to 0x10010024 with ack on cycle 1 -> ch_sel=4'b0010, ch_wr high for 1 cycle, ch_wdata=0xA5, req_done at cycle 2, bus_error=0.
- Read 0x10010020 with ch_rdata[0]=0x55, ack after 3 wait cycles -> ch_rd high for 4 cycles, ReadData=0x55 on req_done.
- Read 0x10010028 with ch_ack never asserted, TIMEOUT=15 -> req_done after 16 ACCESS cycles, ReadData=0xDEADBEEF, bus_error stays 1 until reset.
- Access 0x10010022 (misaligned) -> no strobe, bus_error=1, req_done next cycle. Access 0x10010000 -> is_mmio=0, FSM stays IDLE.
- Assert reset during ACCESS on channel 3 -> all outputs zero next cycle, no req_done. A following access to channel 3 completes normally.
- Ack on channel 2 while channel 1 is selected -> ignored, and the access times out. Ack on the selected channel in the same cycle the counter hits TIMEOUT -> normal completion, no error.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port decoder: FSM states, bus-error data and
// the default peripheral window.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mmioState_t;

  localparam logic [31:0] BUS_ERR_DATA      = 32'hDEADBEEF;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h10010020;

  localparam int CH_UART = 0;
  localparam int CH_GPIO = 1;

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational window match: is AddressIn inside the channel window, is it
// word aligned, and which channel (one-hot) does it address.
module mmio_addr_match #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     NUM_CH      = 4,
  parameter logic [WORD_LENGTH-1:0] BASE_ADDR   = 32'h10010020
) (
  input  logic [WORD_LENGTH-1:0] AddressIn,
  output logic                   inWindow,
  output logic                   aligned,
  output logic [NUM_CH-1:0]      indexOneHot
);

  logic [WORD_LENGTH-1:0] offset;

  // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned compare
  // covers both ends of the window.
  assign offset   = AddressIn - BASE_ADDR;
  assign inWindow = offset < WORD_LENGTH'(4 * NUM_CH);
  assign aligned  = (AddressIn[1:0] == 2'b00);

  always_comb begin
    indexOneHot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      indexOneHot[i] = inWindow && (offset[WORD_LENGTH-1:2] == (WORD_LENGTH-2)'(i));
    end
  end

endmodule

// File: rtl/mmio_port_decoder.sv
// MMIO decoder and access sequencer: latches a one-hot channel select, drives a
// read/write strobe until the channel acks or the timeout expires.
// Handshake: req_valid is held by the core until req_done (a one-cycle pulse);
// ch_wr/ch_rd stay high until ch_ack of the selected channel is seen.
module mmio_port_decoder
  import mmio_pkg::*;
#(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     NUM_CH      = 4,
  parameter logic [WORD_LENGTH-1:0] BASE_ADDR   = WORD_LENGTH'(DEFAULT_BASE_ADDR),
  parameter int                     TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_write,
  input  logic [WORD_LENGTH-1:0]        AddressIn,
  input  logic [WORD_LENGTH-1:0]        WriteData,
  output logic                          is_mmio,
  output logic [NUM_CH-1:0]             ch_sel,
  output logic                          ch_wr,
  output logic                          ch_rd,
  output logic [WORD_LENGTH-1:0]        ch_wdata,
  input  logic [NUM_CH-1:0]             ch_ack,
  input  logic [NUM_CH*WORD_LENGTH-1:0] ch_rdata,
  output logic                          req_done,
  output logic [WORD_LENGTH-1:0]        ReadData,
  output logic                          bus_error,
  output mmioState_t                    dbgState
);

  mmioState_t             state, stateNext;
  logic [7:0]             count, countNext;
  logic [NUM_CH-1:0]      selNext;
  logic                   wrNext, rdNext, doneNext, errNext;
  logic [WORD_LENGTH-1:0] wdataNext, readNext, selRdata;
  logic                   inWindow, aligned, ackSel;
  logic [NUM_CH-1:0]      indexOneHot;

  mmio_addr_match #(
    .WORD_LENGTH (WORD_LENGTH),
    .NUM_CH      (NUM_CH),
    .BASE_ADDR   (BASE_ADDR)
  ) uMatch (
    .AddressIn   (AddressIn),
    .inWindow    (inWindow),
    .aligned     (aligned),
    .indexOneHot (indexOneHot)
  );

  assign is_mmio  = inWindow & aligned;
  assign ackSel   = |(ch_ack & ch_sel);
  assign dbgState = state;

  always_comb begin
    selRdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) selRdata = selRdata | ch_rdata[i*WORD_LENGTH +: WORD_LENGTH];
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    selNext   = ch_sel;
    wrNext    = ch_wr;
    rdNext    = ch_rd;
    wdataNext = ch_wdata;
    doneNext  = 1'b0;
    readNext  = ReadData;
    errNext   = bus_error;
    case (state)
      IDLE: begin
        if (req_valid && is_mmio) begin
          stateNext = ACCESS;
          selNext   = indexOneHot;
          wdataNext = WriteData;
          wrNext    = req_write;
          rdNext    = ~req_write;
          countNext = '0;
        end else if (req_valid && inWindow && !aligned) begin
          stateNext = DONE;
          doneNext  = 1'b1;
          errNext   = 1'b1;
          readNext  = '0;
        end
      end
      ACCESS: begin
        if (ackSel || (count == 8'(TIMEOUT))) begin
          stateNext = DONE;
          doneNext  = 1'b1;
          selNext   = '0;
          wrNext    = 1'b0;
          rdNext    = 1'b0;
          countNext = '0;
          // Ack wins over a coincident timeout.
          if (ackSel) begin
            if (ch_rd) readNext = selRdata;
          end else begin
            errNext = 1'b1;
            if (ch_rd) readNext = WORD_LENGTH'(BUS_ERR_DATA);
          end
        end else begin
          countNext = count + 8'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      ch_sel    <= '0;
      ch_wr     <= 1'b0;
      ch_rd     <= 1'b0;
      ch_wdata  <= '0;
      req_done  <= 1'b0;
      ReadData  <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      ch_sel    <= selNext;
      ch_wr     <= wrNext;
      ch_rd     <= rdNext;
      ch_wdata  <= wdataNext;
      req_done  <= doneNext;
      ReadData  <= readNext;
      bus_error <= errNext;
    end
  end

endmodule

// File: tb/tb_mmio_port_decoder.sv
// Randomized bench for mmio_port_decoder with a transaction-level reference
// model (expected latency, strobe length, read data and sticky error).
module tb_mmio_port_decoder;
  import mmio_pkg::*;

  localparam int          W    = 32;
  localparam int          NCH  = 4;
  localparam int          TO   = 15;
  localparam logic [31:0] BASE = 32'h10010020;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           req_valid, req_write;
  logic [W-1:0]   AddressIn, WriteData;
  logic           is_mmio;
  logic [NCH-1:0] ch_sel;
  logic           ch_wr, ch_rd;
  logic [W-1:0]   ch_wdata;
  logic [NCH-1:0] ch_ack;
  logic [NCH*W-1:0] ch_rdata;
  logic           req_done;
  logic [W-1:0]   ReadData;
  logic           bus_error;
  mmioState_t     dbgState;

  mmio_port_decoder #(
    .WORD_LENGTH (W),
    .NUM_CH      (NCH),
    .BASE_ADDR   (BASE),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .AddressIn (AddressIn),
    .WriteData (WriteData),
    .is_mmio   (is_mmio),
    .ch_sel    (ch_sel),
    .ch_wr     (ch_wr),
    .ch_rd     (ch_rd),
    .ch_wdata  (ch_wdata),
    .ch_ack    (ch_ack),
    .ch_rdata  (ch_rdata),
    .req_done  (req_done),
    .ReadData  (ReadData),
    .bus_error (bus_error),
    .dbgState  (dbgState)
  );

  // scoreboard
  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] expRd;
  logic        expErr;
  logic [31:0] rdWords [NCH];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset     = 1'b1;
    req_valid = 1'b0;
    ch_ack    = '0;
    tick;
    reset  = 1'b0;
    expRd  = '0;
    expErr = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkEq({tag, "_sel"},   32'(ch_sel), 32'd0);
    checkEq({tag, "_strb"},  {30'd0, ch_wr, ch_rd}, 32'd0);
    checkEq({tag, "_done"},  32'(req_done), 32'd0);
    checkEq({tag, "_wdata"}, ch_wdata, 32'd0);
    checkEq({tag, "_rdata"}, ReadData, 32'd0);
    checkEq({tag, "_err"},   32'(bus_error), 32'd0);
    checkEq({tag, "_state"}, 32'(dbgState), 32'(IDLE));
  endtask

  // driver + model for one access; ackDelay counts strobe cycles before ack
  task automatic doAccess(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int ackDelay, input int ackCh, input logic noise);
    logic [31:0]    off, rdExp;
    logic           inWin, mis, errExp;
    logic [NCH-1:0] selMask;
    int             idx, expStrobes, strobes, doneAt;
    off     = addr - BASE;
    inWin   = off < 32'(4 * NCH);
    mis     = inWin && (addr[1:0] != 2'b00);
    idx     = int'(off >> 2);
    selMask = (inWin && !mis) ? (NCH'(1) << idx) : '0;
    for (int i = 0; i < NCH; i++) begin
      rdWords[i] = $urandom;
      ch_rdata[i*W +: W] = rdWords[i];
    end
    req_valid = 1'b1;
    req_write = wr;
    AddressIn = addr;
    WriteData = wdata;
    ch_ack    = '0;
    #1;
    checkEq("is_mmio", 32'(is_mmio), 32'(inWin && !mis));
    if (!inWin) begin
      for (int c = 0; c < 4; c++) begin
        tick;
        checkEq("ignored", {29'd0, req_done, ch_wr, ch_rd}, 32'd0);
      end
      req_valid = 1'b0;
      return;
    end
    if (mis) begin
      expStrobes = 0;
      errExp     = 1'b1;
      rdExp      = 32'd0;
    end else if (ackCh == idx && ackDelay <= TO) begin
      expStrobes = ackDelay + 1;
      errExp     = 1'b0;
      rdExp      = wr ? expRd : rdWords[idx];
    end else begin
      expStrobes = TO + 1;
      errExp     = 1'b1;
      rdExp      = wr ? expRd : 32'hDEADBEEF;
    end
    strobes = 0;
    doneAt  = -1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (ch_wr || ch_rd) begin
        checkEq("ch_sel", 32'(ch_sel), 32'(selMask));
        checkEq("strobe_dir", {30'd0, ch_wr, ch_rd}, wr ? 32'd2 : 32'd1);
        if (wr) checkEq("ch_wdata", ch_wdata, wdata);
        ch_ack = (noise ? NCH'($urandom) : '0) & ~selMask;
        if (strobes == ackDelay) ch_ack = ch_ack | (NCH'(1) << ackCh);
        strobes++;
      end else begin
        ch_ack = '0;
      end
      if (req_done) begin
        doneAt = c;
        break;
      end
    end
    req_valid = 1'b0;
    ch_ack    = '0;
    expErr    = expErr | errExp;
    expRd     = rdExp;
    checkEq("done_cycle", 32'(doneAt), 32'(expStrobes + 1));
    checkEq("strobe_len", 32'(strobes), 32'(expStrobes));
    checkEq("ReadData", ReadData, expRd);
    checkEq("bus_error", 32'(bus_error), 32'(expErr));
    checkEq("sel_clear", 32'(ch_sel), 32'd0);
    tick;
    checkEq("done_pulse", 32'(req_done), 32'd0);
  endtask

  task automatic resetMidAccess;
    for (int i = 0; i < NCH; i++) ch_rdata[i*W +: W] = $urandom;
    req_valid = 1'b1;
    req_write = 1'b0;
    AddressIn = BASE + 32'd12;
    WriteData = $urandom;
    ch_ack    = '0;
    for (int c = 0; c < 4; c++) tick;
    checkEq("mid_sel", 32'(ch_sel), 32'b1000);
    reset     = 1'b1;
    req_valid = 1'b0;
    tick;
    checkIdleOutputs("mid_rst");
    reset  = 1'b0;
    expRd  = '0;
    expErr = 1'b0;
    tick;
    checkEq("mid_nodone", 32'(req_done), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    AddressIn = '0;
    WriteData = '0;
    ch_ack    = '0;
    ch_rdata  = '0;
    tick;
    tick;
    checkIdleOutputs("reset");
    reset  = 1'b0;
    expRd  = '0;
    expErr = 1'b0;
    tick;

    doAccess(BASE + 32'(4 * CH_GPIO), 1'b1, 32'h000000A5, 0, CH_GPIO, 1'b0);
    doAccess(BASE, 1'b0, 32'h0, 3, CH_UART, 1'b0);
    doAccess(BASE + 32'd8, 1'b0, 32'h0, 100, 2, 1'b0);
    doAccess(BASE + 32'd2, 1'b0, 32'h0, 0, 0, 1'b0);
    doAccess(32'h10010000, 1'b0, 32'h0, 0, 0, 1'b0);
    doAccess(BASE + 32'd16, 1'b1, 32'h1234, 0, 0, 1'b0);
    resetMidAccess();
    doAccess(BASE + 32'd12, 1'b0, 32'h0, 1, 3, 1'b1);
    doAccess(BASE + 32'd4, 1'b0, 32'h0, 0, 2, 1'b0);
    doReset();
    doAccess(BASE + 32'd4, 1'b0, 32'h0, TO, 1, 1'b1);
    doAccess(BASE + 32'd8, 1'b1, 32'hCAFE0001, TO + 1, 2, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int          ch, ackCh, ackDelay;
      logic [31:0] addr;
      ch       = $urandom_range(0, NCH - 1);
      addr     = BASE + 32'(4 * ch);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      ackDelay = $urandom_range(0, TO + 3);
      ackCh    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, NCH - 1) : ch;
      doAccess(addr, 1'($urandom_range(0, 1)), $urandom, ackDelay, ackCh, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) doReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
